// File: rtl/rename_pkg.sv
// ---------------------------------------------------------------------------
// rename_pkg
// Shared rename-stage definitions used by the freelist, the rename table and
// the physical-register release queue.
//   NUM_PREGS / PREG_W : physical register count and number width
//   preg_t             : physical register number
//   RELQ_DEPTH         : default release-queue depth
//   relq_ptr_t         : release-queue head/tail pointer at default depth
//   relq_min2()        : clamps an entry count to the 0..2 offer width
// ---------------------------------------------------------------------------
package rename_pkg;

  localparam int NUM_PREGS  = 64;
  localparam int PREG_W     = $clog2(NUM_PREGS);
  localparam int RELQ_DEPTH = 8;
  localparam int RELQ_PTR_W = $clog2(RELQ_DEPTH);

  typedef logic [PREG_W-1:0]     preg_t;
  typedef logic [RELQ_PTR_W-1:0] relq_ptr_t;

  // Number of entries that can be offered in one cycle: min(n, 2).
  function automatic logic [1:0] relq_min2(input int unsigned n);
    logic [1:0] r;
    if (n >= 32'd2) begin
      r = 2'd2;
    end else begin
      r = n[1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/preg_pending_mask.sv
// ---------------------------------------------------------------------------
// preg_pending_mask
// One bit per physical register marking "currently queued for release".
// Used by preg_release_queue to drop duplicate releases.
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   clr_valid_1/2, clr_preg_1/2   pregs leaving the queue this cycle
//   set_valid_1/2, set_preg_1/2   pregs entering the queue this cycle
//   query_preg_1/2           pregs being released this cycle
//   query_hit_1/2            queried preg is pending and not leaving now
// A preg that leaves and is re-released in the same cycle is not a hit,
// and the mask applies clears before sets so it ends up pending again.
// ---------------------------------------------------------------------------
module preg_pending_mask #(
  parameter int  NUM_PREGS = rename_pkg::NUM_PREGS,
  localparam int PW        = $clog2(NUM_PREGS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr_valid_1,
  input  logic [PW-1:0] clr_preg_1,
  input  logic          clr_valid_2,
  input  logic [PW-1:0] clr_preg_2,
  input  logic          set_valid_1,
  input  logic [PW-1:0] set_preg_1,
  input  logic          set_valid_2,
  input  logic [PW-1:0] set_preg_2,
  input  logic [PW-1:0] query_preg_1,
  input  logic [PW-1:0] query_preg_2,
  output logic          query_hit_1,
  output logic          query_hit_2
);

  logic [NUM_PREGS-1:0] mask_r;
  logic [NUM_PREGS-1:0] clr_vec_s;
  logic [NUM_PREGS-1:0] set_vec_s;
  logic [NUM_PREGS-1:0] mask_next_s;

  // Pending lookup with this cycle's dequeues already removed.
  always_comb begin
    query_hit_1 = mask_r[query_preg_1]
                  && !(clr_valid_1 && (clr_preg_1 == query_preg_1))
                  && !(clr_valid_2 && (clr_preg_2 == query_preg_1));
    query_hit_2 = mask_r[query_preg_2]
                  && !(clr_valid_1 && (clr_preg_1 == query_preg_2))
                  && !(clr_valid_2 && (clr_preg_2 == query_preg_2));
  end

  // Next mask: clear dequeued pregs first, then set enqueued ones.
  always_comb begin
    clr_vec_s = '0;
    set_vec_s = '0;
    clr_vec_s[clr_preg_1] = clr_vec_s[clr_preg_1] | clr_valid_1;
    clr_vec_s[clr_preg_2] = clr_vec_s[clr_preg_2] | clr_valid_2;
    set_vec_s[set_preg_1] = set_vec_s[set_preg_1] | set_valid_1;
    set_vec_s[set_preg_2] = set_vec_s[set_preg_2] | set_valid_2;
    mask_next_s = (mask_r & ~clr_vec_s) | set_vec_s;
  end

  // Mask register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_r <= '0;
    end else begin
      mask_r <= mask_next_s;
    end
  end

endmodule

// File: rtl/preg_release_queue.sv
// ---------------------------------------------------------------------------
// preg_release_queue
// Deallocation side of the physical-register freelist. Buffers up to two
// released pregs per cycle from ROB commit in a circular FIFO and offers up
// to two per cycle back to the freelist.
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   rel_valid_1/2, rel_preg_1/2   releases from commit slots (slot 1 older)
//   rel_ready                     room for two releases (registered state)
//   free_valid, free_count        offer present / number offered (0..2)
//   free_preg_1/2                 oldest / second-oldest queued preg
//   free_ready                    freelist takes everything offered
//   occupancy                     current entry count
//   overflow_err                  sticky: release arrived while not ready
//   dup_err (RELQ_DUP_CHECK_EN)   sticky: duplicate release was dropped
// Build option: define RELQ_DUP_CHECK_EN to add duplicate-release filtering.
// ---------------------------------------------------------------------------
module preg_release_queue #(
  parameter int  NUM_PREGS = rename_pkg::NUM_PREGS,
  parameter int  DEPTH     = rename_pkg::RELQ_DEPTH,
  localparam int PW        = $clog2(NUM_PREGS),
  localparam int AW        = $clog2(DEPTH),
  localparam int CW        = AW + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          rel_valid_1,
  input  logic [PW-1:0] rel_preg_1,
  input  logic          rel_valid_2,
  input  logic [PW-1:0] rel_preg_2,
  output logic          rel_ready,
  output logic          free_valid,
  output logic [1:0]    free_count,
  output logic [PW-1:0] free_preg_1,
  output logic [PW-1:0] free_preg_2,
  input  logic          free_ready,
  output logic [CW-1:0] occupancy,
`ifdef RELQ_DUP_CHECK_EN
  output logic          dup_err,
`endif
  output logic          overflow_err
);

  import rename_pkg::*;

  logic [PW-1:0] mem_r [DEPTH];
  logic [AW-1:0] head_r;
  logic [AW-1:0] tail_r;
  logic [CW-1:0] occ_r;
  logic          overflow_err_r;

  logic          rel_ready_s;
  logic          keep_1_s;
  logic          keep_2_s;
  logic [1:0]    n_in_s;
  logic          accept_s;
  logic [1:0]    n_in_acc_s;
  logic [1:0]    n_out_s;
  logic [AW-1:0] wr_idx_2_s;
  logic [1:0]    free_count_s;
  logic [PW-1:0] free_preg_1_s;
  logic [PW-1:0] free_preg_2_s;

  // Offer side: derived only from registered state, never from rel_* inputs.
  always_comb begin
    free_count_s = relq_min2(32'(occ_r));
    if (occ_r != '0) begin
      free_preg_1_s = mem_r[head_r];
    end else begin
      free_preg_1_s = '0;
    end
    if (occ_r >= CW'(2)) begin
      free_preg_2_s = mem_r[head_r + AW'(1)];
    end else begin
      free_preg_2_s = '0;
    end
    if (free_ready && (occ_r != '0)) begin
      n_out_s = free_count_s;
    end else begin
      n_out_s = 2'd0;
    end
  end

  // Two free slots guaranteed, so enqueue never touches entries being read.
  assign rel_ready_s = (occ_r <= CW'(DEPTH - 2));

`ifdef RELQ_DUP_CHECK_EN
  logic hit_1_s;
  logic hit_2_s;
  logic same_s;
  logic dup_seen_s;
  logic dup_err_r;

  preg_pending_mask #(
    .NUM_PREGS (NUM_PREGS)
  ) u_pending_mask (
    .clk          (clk),
    .reset_n      (reset_n),
    .clr_valid_1  (n_out_s != 2'd0),
    .clr_preg_1   (free_preg_1_s),
    .clr_valid_2  (n_out_s == 2'd2),
    .clr_preg_2   (free_preg_2_s),
    .set_valid_1  (accept_s && keep_1_s),
    .set_preg_1   (rel_preg_1),
    .set_valid_2  (accept_s && keep_2_s),
    .set_preg_2   (rel_preg_2),
    .query_preg_1 (rel_preg_1),
    .query_preg_2 (rel_preg_2),
    .query_hit_1  (hit_1_s),
    .query_hit_2  (hit_2_s)
  );

  // Drop releases already pending, and slot 2 when it repeats slot 1.
  always_comb begin
    same_s     = rel_valid_1 && rel_valid_2 && (rel_preg_1 == rel_preg_2);
    keep_1_s   = rel_valid_1 && !hit_1_s;
    keep_2_s   = rel_valid_2 && !hit_2_s && !same_s;
    dup_seen_s = (rel_valid_1 && hit_1_s) || (rel_valid_2 && (hit_2_s || same_s));
  end

  // Sticky duplicate-release flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dup_err_r <= 1'b0;
    end else if (dup_seen_s) begin
      dup_err_r <= 1'b1;
    end
  end

  assign dup_err = dup_err_r;
`else
  // Every valid release is kept as-is.
  always_comb begin
    keep_1_s = rel_valid_1;
    keep_2_s = rel_valid_2;
  end
`endif

  // Enqueue control: compaction puts a lone slot-2 release at tail.
  always_comb begin
    n_in_s   = {1'b0, keep_1_s} + {1'b0, keep_2_s};
    accept_s = rel_ready_s && (n_in_s != 2'd0);
    if (accept_s) begin
      n_in_acc_s = n_in_s;
    end else begin
      n_in_acc_s = 2'd0;
    end
    if (keep_1_s) begin
      wr_idx_2_s = tail_r + AW'(1);
    end else begin
      wr_idx_2_s = tail_r;
    end
  end

  // Storage writes; contents need no reset because occupancy gates the reads.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      if (keep_1_s) begin
        mem_r[tail_r] <= rel_preg_1;
      end
      if (keep_2_s) begin
        mem_r[wr_idx_2_s] <= rel_preg_2;
      end
    end
  end

  // Pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_r         <= '0;
      tail_r         <= '0;
      occ_r          <= '0;
      overflow_err_r <= 1'b0;
    end else begin
      tail_r <= tail_r + AW'(n_in_acc_s);
      head_r <= head_r + AW'(n_out_s);
      occ_r  <= occ_r + CW'(n_in_acc_s) - CW'(n_out_s);
      if (!rel_ready_s && (n_in_s != 2'd0)) begin
        overflow_err_r <= 1'b1;
      end
    end
  end

  assign rel_ready    = rel_ready_s;
  assign free_valid   = (occ_r != '0);
  assign free_count   = free_count_s;
  assign free_preg_1  = free_preg_1_s;
  assign free_preg_2  = free_preg_2_s;
  assign occupancy    = occ_r;
  assign overflow_err = overflow_err_r;

endmodule

// File: tb/tb_preg_release_queue.sv
// Self-checking bench for preg_release_queue: directed scenarios plus a
// randomized run checked against a queue-based reference model.
module tb_preg_release_queue;

  localparam int DEPTH = 8;
  localparam int PW    = 6;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          rel_valid_1 = 1'b0;
  logic [PW-1:0] rel_preg_1 = '0;
  logic          rel_valid_2 = 1'b0;
  logic [PW-1:0] rel_preg_2 = '0;
  logic          rel_ready;
  logic          free_valid;
  logic [1:0]    free_count;
  logic [PW-1:0] free_preg_1;
  logic [PW-1:0] free_preg_2;
  logic          free_ready = 1'b0;
  logic [3:0]    occupancy;
  logic          overflow_err;
`ifdef RELQ_DUP_CHECK_EN
  logic          dup_err;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: contents of the queue in order, plus sticky flags.
  int mq[$];
  bit m_ovf = 1'b0;
  bit m_dup = 1'b0;

  preg_release_queue #(.NUM_PREGS(64), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rel_valid_1  (rel_valid_1),
    .rel_preg_1   (rel_preg_1),
    .rel_valid_2  (rel_valid_2),
    .rel_preg_2   (rel_preg_2),
    .rel_ready    (rel_ready),
    .free_valid   (free_valid),
    .free_count   (free_count),
    .free_preg_1  (free_preg_1),
    .free_preg_2  (free_preg_2),
    .free_ready   (free_ready),
    .occupancy    (occupancy),
`ifdef RELQ_DUP_CHECK_EN
    .dup_err      (dup_err),
`endif
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1);
  end

  function automatic bit in_q(input int p);
    foreach (mq[i]) begin
      if (mq[i] == p) return 1'b1;
    end
    return 1'b0;
  endfunction

  // One clock of the specification's rules applied to the model queue.
  task automatic model_step(input bit v1, input int p1, input bit v2, input int p2, input bit fr);
    int sz;
    int nout;
    bit rdy;
    bit k1;
    bit k2;
    sz   = mq.size();
    rdy  = (sz <= DEPTH - 2);
    k1   = v1;
    k2   = v2;
    nout = 0;
    if (fr && sz > 0) nout = (sz >= 2) ? 2 : 1;
    repeat (nout) void'(mq.pop_front());
`ifdef RELQ_DUP_CHECK_EN
    if (v1 && v2 && p1 == p2) begin k2 = 1'b0; m_dup = 1'b1; end
    if (k1 && in_q(p1)) begin k1 = 1'b0; m_dup = 1'b1; end
    if (k2 && in_q(p2)) begin k2 = 1'b0; m_dup = 1'b1; end
`endif
    if (k1 || k2) begin
      if (!rdy) begin
        m_ovf = 1'b1;
      end else begin
        if (k1) mq.push_back(p1);
        if (k2) mq.push_back(p2);
      end
    end
  endtask

  // Drive one cycle of inputs, update the model at the edge, then idle inputs.
  task automatic cycle(input bit v1, input int p1, input bit v2, input int p2, input bit fr);
    rel_valid_1 = v1;
    rel_preg_1  = PW'(p1);
    rel_valid_2 = v2;
    rel_preg_2  = PW'(p2);
    free_ready  = fr;
    @(posedge clk);
    model_step(v1, p1, v2, p2, fr);
    #1;
    rel_valid_1 = 1'b0;
    rel_valid_2 = 1'b0;
    free_ready  = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    m_dup = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (free_valid !== 1'b0) begin n_err++; $display("FAIL reset_free_valid: got %0b want 0", free_valid); end
    n_cmp++; if (rel_ready !== 1'b1) begin n_err++; $display("FAIL reset_rel_ready: got %0b want 1", rel_ready); end
    n_cmp++; if (occupancy !== 4'd0) begin n_err++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
    n_cmp++; if (overflow_err !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %0b want 0", overflow_err); end
    n_cmp++; if (free_count !== 2'd0 || free_preg_1 !== 6'd0 || free_preg_2 !== 6'd0) begin
      n_err++; $display("FAIL reset_free_outs: got cnt=%0d p1=%0d p2=%0d want 0 0 0", free_count, free_preg_1, free_preg_2);
    end
    cycle(1'b0, 0, 1'b0, 0, 1'b1);
    n_cmp++; if (occupancy !== 4'd0 || free_valid !== 1'b0) begin
      n_err++; $display("FAIL idle_ready_noeffect: got occ=%0d fv=%0b want 0 0", occupancy, free_valid);
    end
  endtask

  task automatic test_pair();
    cycle(1'b1, 3, 1'b1, 7, 1'b0);
    n_cmp++; if (free_count !== 2'd2 || free_preg_1 !== 6'd3 || free_preg_2 !== 6'd7) begin
      n_err++; $display("FAIL pair_offer: got cnt=%0d p1=%0d p2=%0d want 2 3 7", free_count, free_preg_1, free_preg_2);
    end
    cycle(1'b0, 0, 1'b0, 0, 1'b1);
    n_cmp++; if (occupancy !== 4'd0 || free_valid !== 1'b0) begin
      n_err++; $display("FAIL pair_drain: got occ=%0d fv=%0b want 0 0", occupancy, free_valid);
    end
  endtask

  task automatic test_compaction();
    cycle(1'b0, 0, 1'b1, 12, 1'b0);
    n_cmp++; if (free_count !== 2'd1 || free_preg_1 !== 6'd12 || occupancy !== 4'd1) begin
      n_err++; $display("FAIL slot2_compact: got cnt=%0d p1=%0d occ=%0d want 1 12 1", free_count, free_preg_1, occupancy);
    end
    cycle(1'b0, 0, 1'b0, 0, 1'b1);
    n_cmp++; if (occupancy !== 4'd0) begin n_err++; $display("FAIL slot2_drain: got occ=%0d want 0", occupancy); end
  endtask

  task automatic test_async_reset();
    cycle(1'b1, 40, 1'b1, 41, 1'b0);
    cycle(1'b1, 42, 1'b1, 43, 1'b0);
    cycle(1'b1, 44, 1'b0, 0, 1'b0);
    n_cmp++; if (occupancy !== 4'd5) begin n_err++; $display("FAIL async_pre_occ: got %0d want 5", occupancy); end
    #3;
    reset_n = 1'b0;
    #1;
    n_cmp++; if (occupancy !== 4'd0 || free_valid !== 1'b0 || rel_ready !== 1'b1) begin
      n_err++; $display("FAIL async_reset: got occ=%0d fv=%0b rdy=%0b want 0 0 1", occupancy, free_valid, rel_ready);
    end
    do_reset();
  endtask

  task automatic test_overflow();
    logic [20:0] got;
    logic [20:0] exp;
    cycle(1'b1, 30, 1'b1, 31, 1'b0);
    cycle(1'b1, 32, 1'b1, 33, 1'b0);
    cycle(1'b1, 34, 1'b1, 35, 1'b0);
    n_cmp++; if (rel_ready !== 1'b1 || occupancy !== 4'd6) begin
      n_err++; $display("FAIL ready_at_6: got rdy=%0b occ=%0d want 1 6", rel_ready, occupancy);
    end
    cycle(1'b1, 36, 1'b0, 0, 1'b0);
    n_cmp++; if (rel_ready !== 1'b0 || occupancy !== 4'd7) begin
      n_err++; $display("FAIL ready_at_7: got rdy=%0b occ=%0d want 0 7", rel_ready, occupancy);
    end
    cycle(1'b1, 20, 1'b0, 0, 1'b0);
    n_cmp++; if (overflow_err !== 1'b1 || occupancy !== 4'd7 || free_preg_1 !== 6'd30) begin
      n_err++; $display("FAIL overflow_set: got ovf=%0b occ=%0d p1=%0d want 1 7 30", overflow_err, occupancy, free_preg_1);
    end
    cycle(1'b0, 0, 1'b0, 0, 1'b0);
    n_cmp++; if (overflow_err !== 1'b1) begin n_err++; $display("FAIL overflow_sticky: got %0b want 1", overflow_err); end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 0, 1'b0, 0, 1'b1);
      got = {free_valid, free_count, free_preg_1, free_preg_2, occupancy, rel_ready, overflow_err};
      exp = {mq.size() != 0, 2'((mq.size() >= 2) ? 2 : mq.size()),
             6'((mq.size() >= 1) ? mq[0] : 0), 6'((mq.size() >= 2) ? mq[1] : 0),
             4'(mq.size()), mq.size() <= DEPTH - 2, m_ovf};
      n_cmp++; if (got !== exp) begin n_err++; $display("FAIL overflow_drain: got %h want %h", got, exp); end
    end
    do_reset();
    n_cmp++; if (overflow_err !== 1'b0) begin n_err++; $display("FAIL overflow_clear: got %0b want 0", overflow_err); end
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, 2 * k, 1'b1, 2 * k + 1, 1'b1);
      n_cmp++; if (occupancy !== 4'd2 || free_preg_1 !== 6'(2 * k) || free_preg_2 !== 6'(2 * k + 1)) begin
        n_err++; $display("FAIL wrap_%0d: got occ=%0d p1=%0d p2=%0d want 2 %0d %0d", k, occupancy, free_preg_1, free_preg_2, 2 * k, 2 * k + 1);
      end
    end
    cycle(1'b0, 0, 1'b0, 0, 1'b1);
    n_cmp++; if (occupancy !== 4'd0) begin n_err++; $display("FAIL wrap_drain: got occ=%0d want 0", occupancy); end
  endtask

  task automatic test_random();
    logic [20:0] got;
    logic [20:0] exp;
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      cycle(($urandom % 3) != 0, int'($urandom_range(0, 63)), ($urandom % 3) != 0,
            int'($urandom_range(0, 63)), ($urandom % 2) == 0);
      got = {free_valid, free_count, free_preg_1, free_preg_2, occupancy, rel_ready, overflow_err};
      exp = {mq.size() != 0, 2'((mq.size() >= 2) ? 2 : mq.size()),
             6'((mq.size() >= 1) ? mq[0] : 0), 6'((mq.size() >= 2) ? mq[1] : 0),
             4'(mq.size()), mq.size() <= DEPTH - 2, m_ovf};
      n_cmp++; if (got !== exp) begin n_err++; $display("FAIL random_%0d: got %h want %h", i, got, exp); end
`ifdef RELQ_DUP_CHECK_EN
      n_cmp++; if (dup_err !== m_dup) begin n_err++; $display("FAIL random_dup_%0d: got %0b want %0b", i, dup_err, m_dup); end
`endif
    end
    do_reset();
  endtask

`ifdef RELQ_DUP_CHECK_EN
  task automatic test_dup();
    do_reset();
    cycle(1'b1, 9, 1'b0, 0, 1'b0);
    n_cmp++; if (occupancy !== 4'd1 || dup_err !== 1'b0) begin
      n_err++; $display("FAIL dup_first: got occ=%0d dup=%0b want 1 0", occupancy, dup_err);
    end
    cycle(1'b1, 9, 1'b0, 0, 1'b0);
    n_cmp++; if (occupancy !== 4'd1 || dup_err !== 1'b1) begin
      n_err++; $display("FAIL dup_repeat: got occ=%0d dup=%0b want 1 1", occupancy, dup_err);
    end
    do_reset();
    cycle(1'b1, 5, 1'b1, 5, 1'b0);
    n_cmp++; if (occupancy !== 4'd1 || free_preg_1 !== 6'd5 || dup_err !== 1'b1) begin
      n_err++; $display("FAIL dup_same_cycle: got occ=%0d p1=%0d dup=%0b want 1 5 1", occupancy, free_preg_1, dup_err);
    end
    do_reset();
    cycle(1'b1, 11, 1'b0, 0, 1'b0);
    cycle(1'b1, 11, 1'b0, 0, 1'b1);
    n_cmp++; if (occupancy !== 4'd1 || free_preg_1 !== 6'd11 || dup_err !== 1'b0) begin
      n_err++; $display("FAIL dup_deq_rerelease: got occ=%0d p1=%0d dup=%0b want 1 11 0", occupancy, free_preg_1, dup_err);
    end
    do_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_pair();
    test_compaction();
    test_async_reset();
    test_overflow();
    test_wrap();
    test_random();
`ifdef RELQ_DUP_CHECK_EN
    test_dup();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
